wb_stage: RTL
=============

# wb_stage

Parametrised MIPS writeback stage with a registered MEM/WB boundary and sub-word load extension. It merges results from a multi-cycle unit (mult/div, MFHI/MFLO-style late results) through a small retire FIFO onto the single register-file write port. It sits between the MEM stage and the register file and exports pending-write status to the hazard unit. It adds holding, arbitration, WAW kill and anti-starvation behaviour on top of a plain result mux.

## Interface
Parameters:
- DATA_W, 32, datapath width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 4, retire FIFO entries (power of two, ≥2)
- STARVE_MAX, 8, consecutive blocked cycles before forced drain

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- mem_valid  in  1  MEM stage presents an instruction
- mem_regwrite  in  1  instruction writes a register
- mem_waddr  in  ADDR_W  destination register
- mem_wsel  in  2  result select: 0 ALU, 1 DM, 2 PC+8, 3 reserved (treated as ALU)
- mem_ldtype  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU
- mem_boff  in  2  load byte offset (little-endian)
- mem_alu, mem_dm, mem_pc8  in  DATA_W  candidate results
- md_valid  in  1  multi-cycle result offered
- md_waddr  in  ADDR_W  its destination
- md_wdata  in  DATA_W  its data
- md_ready  out  1  FIFO can accept (= not full)
- q_addr0, q_addr1  in  ADDR_W  hazard query addresses
- pend0, pend1  out  1  query address has a live FIFO entry
- wb_hold  out  1  MEM stage must hold its outputs this cycle
- reg_we  out  1  register-file write enable
- reg_waddr  out  ADDR_W  write address
- reg_wdata  out  DATA_W  write data

## Operation
- WB register: on each edge, if wb_hold=0, it captures mem_valid&mem_regwrite plus waddr and the selected/extended data. If wb_hold=1, it loads a bubble.
- Load extension (mem_wsel=1): LB/LBU pick byte mem_boff. LH/LHU pick halfword mem_boff[1], ignoring mem_boff[0]. Sign- or zero-extend to DATA_W. Undefined ldtype values behave as LW.
- md accept: a handshake occurs when md_valid&md_ready. The entry is pushed unless md_waddr=0, in which case it is accepted and dropped.
- Write port arbitration, combinational from state:
  - A WB register write with waddr≠0 has priority.
  - Otherwise the FIFO head, if non-empty, is written and popped at the edge.
  - A WB write to register 0 leaves reg_we=0 and lets the FIFO drain.
- WAW kill: when the WB register writes addr X, every live FIFO entry with waddr X is invalidated at that edge. Killed entries pop without asserting reg_we.
- A same-cycle md push is not killed; md results are treated as younger.
- pendN = OR over live entries of (waddr==q_addrN) & q_addrN≠0.
- Starvation: the counter increments each cycle the FIFO is non-empty and the port is taken by the WB register. It clears on any pop. When it reaches STARVE_MAX, wb_hold is registered high for exactly one cycle and the counter clears.

## Timing
- Reset values: reg_we=0, reg_waddr=0, reg_wdata=0, wb_hold=0, FIFO empty, md_ready=1, pend0=pend1=0, counter=0, WB register invalid.
- MEM→register-file latency is 1 cycle: inputs sampled at edge t, write asserted during cycle t+1.
- md→register-file minimum latency is 1 cycle: pushed at edge t, written in cycle t+1 if the port is free.
- md_ready depends only on FIFO occupancy. There is no push-through-pop when full.
- Kill and pop of the same head entry in one cycle: the pop wins and no write occurs.
- A forced-drain cycle is wb_hold high in cycle t, a bubble in WB in t+1, and the FIFO head written in t+1.
- Reset asserted mid-operation discards FIFO contents and the WB register immediately.

## Configuration
- WB_SUBWORD_EN:
  - Defined: byte/halfword extension as above.
  - Undefined: mem_dm passes through verbatim, and mem_ldtype and mem_boff are ignored.

## Structure
- Shared package/header wb_defs holds the WSEL_* and LD_* encodings and the default widths.
- Sub-module wb_retire_fifo holds the FIFO storage, per-entry valid bits, kill compare and pend query ports. wb_stage keeps the WB register, extension, arbitration and starvation counter.

## Test plan
- Reset, then LW with regwrite, waddr=8, dm=0xDEADBEEF → reg_we=1, waddr=8, wdata=0xDEADBEEF exactly one cycle later.
- LB boff=3, dm=0x80112233 → wdata=0xFFFFFF80. LHU boff=2 → 0x00008011. With WB_SUBWORD_EN undefined → 0x80112233.
- md push waddr=9 data=5 while the pipeline writes every cycle → pend for q=9 stays high; STARVE_MAX cycles later wb_hold pulses once; the next cycle writes 9←5 and pend drops.
- md push waddr=10, then pipeline write to 10 before drain → entry killed, and r10 receives only the pipeline value.
- Fill FIFO_DEPTH entries with WB busy → md_ready=0; on the first pop md_ready=1. md push with waddr=0 is accepted and never written.
- Pipeline write to $0 with a FIFO entry pending → reg_we carries the FIFO entry that cycle.

Source files
------------

// File: rtl/wb_defs.sv
// Shared encodings and default widths for the writeback stage and its retire FIFO.
package wb_defs;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 5;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_STARVE_MAX = 8;

  typedef enum logic [1:0] {
    WSEL_ALU = 2'd0,
    WSEL_DM  = 2'd1,
    WSEL_PC8 = 2'd2,
    WSEL_RSV = 2'd3
  } wselT;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LB  = 3'd1,
    LD_LBU = 3'd2,
    LD_LH  = 3'd3,
    LD_LHU = 3'd4
  } ldTypeT;

endpackage

// File: rtl/wb_retire_fifo.sv
// Retire FIFO for late multi-cycle results: per-entry live bits, WAW kill by
// address, and two hazard query ports reporting live pending writes.
module wb_retire_fifo
  import wb_defs::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] pushAddr,
  input  logic [DATA_W-1:0] pushData,
  input  logic              pop,
  input  logic              killEn,
  input  logic [ADDR_W-1:0] killAddr,
  input  logic [ADDR_W-1:0] qAddr0,
  input  logic [ADDR_W-1:0] qAddr1,
  output logic              empty,
  output logic              full,
  output logic              headLive,
  output logic [ADDR_W-1:0] headAddr,
  output logic [DATA_W-1:0] headData,
  output logic              pend0,
  output logic              pend1
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addrMem [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [DEPTH-1:0]  live;
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic [CNT_W-1:0]  count;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign headLive = live[rdPtr];
  assign headAddr = addrMem[rdPtr];
  assign headData = dataMem[rdPtr];

  // NOTE: storage carries no reset; the live bits alone decide whether an entry means anything.
  always_ff @(posedge clk) begin
    if (push) begin
      addrMem[wrPtr] <= pushAddr;
      dataMem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live  <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (killEn && live[i] && (addrMem[i] == killAddr)) live[i] <= 1'b0;
      end
      if (pop) begin
        live[rdPtr] <= 1'b0;
        rdPtr       <= rdPtr + 1'b1;
      end
      // NOTE: the push update is the last non-blocking write to its live bit, so a
      // same-edge push survives a kill of the same address (md results are younger).
      if (push) begin
        live[wrPtr] <= 1'b1;
        wrPtr       <= wrPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    pend0 = 1'b0;
    pend1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pend0 = pend0 | (live[i] && (addrMem[i] == qAddr0));
      pend1 = pend1 | (live[i] && (addrMem[i] == qAddr1));
    end
    pend0 = pend0 && (qAddr0 != '0);
    pend1 = pend1 && (qAddr1 != '0);
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: MEM/WB register with load extension (WB_SUBWORD_EN),
// write-port arbitration against the retire FIFO, WAW kill and forced drain.
module wb_stage
  import wb_defs::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_regwrite,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [1:0]        mem_wsel,
  input  logic [2:0]        mem_ldtype,
  input  logic [1:0]        mem_boff,
  input  logic [DATA_W-1:0] mem_alu,
  input  logic [DATA_W-1:0] mem_dm,
  input  logic [DATA_W-1:0] mem_pc8,
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_waddr,
  input  logic [DATA_W-1:0] md_wdata,
  output logic              md_ready,
  input  logic [ADDR_W-1:0] q_addr0,
  input  logic [ADDR_W-1:0] q_addr1,
  output logic              pend0,
  output logic              pend1,
  output logic              wb_hold,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_waddr,
  output logic [DATA_W-1:0] reg_wdata
);

  localparam int STV_W = $clog2(STARVE_MAX + 1);

  logic              wbValid;
  logic [ADDR_W-1:0] wbAddr;
  logic [DATA_W-1:0] wbData;
  logic [DATA_W-1:0] dmExt;
  logic [DATA_W-1:0] selData;
  logic              wbWrites;
  logic              fifoEmpty;
  logic              fifoFull;
  logic              headLive;
  logic [ADDR_W-1:0] headAddr;
  logic [DATA_W-1:0] headData;
  logic              fifoPush;
  logic              fifoPop;
  logic [STV_W-1:0]  starveCnt;
  logic              holdQ;

  assign wbWrites = wbValid && (wbAddr != '0);
  assign fifoPop  = !wbWrites && !fifoEmpty;
  assign md_ready = !fifoFull;
  assign fifoPush = md_valid && md_ready && (md_waddr != '0);
  assign wb_hold  = holdQ;

`ifdef WB_SUBWORD_EN
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign byteSel = mem_dm[{mem_boff, 3'b000} +: 8];
  assign halfSel = mem_dm[{mem_boff[1], 4'b0000} +: 16];

  always_comb begin
    case (mem_ldtype)
      LD_LB:   dmExt = {{(DATA_W-8){byteSel[7]}}, byteSel};
      LD_LBU:  dmExt = DATA_W'(byteSel);
      LD_LH:   dmExt = {{(DATA_W-16){halfSel[15]}}, halfSel};
      LD_LHU:  dmExt = DATA_W'(halfSel);
      default: dmExt = mem_dm;
    endcase
  end
`else
  logic unusedSubword;

  assign dmExt         = mem_dm;
  assign unusedSubword = ^{mem_ldtype, mem_boff};
`endif

  always_comb begin
    case (mem_wsel)
      WSEL_DM:  selData = dmExt;
      WSEL_PC8: selData = mem_pc8;
      default:  selData = mem_alu;
    endcase
  end

  // A held MEM stage re-presents the same instruction, so WB takes a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbValid <= 1'b0;
      wbAddr  <= '0;
      wbData  <= '0;
    end else if (holdQ) begin
      wbValid <= 1'b0;
    end else begin
      wbValid <= mem_valid && mem_regwrite;
      wbAddr  <= mem_waddr;
      wbData  <= selData;
    end
  end

  always_comb begin
    reg_we    = 1'b0;
    reg_waddr = '0;
    reg_wdata = '0;
    if (wbWrites) begin
      reg_we    = 1'b1;
      reg_waddr = wbAddr;
      reg_wdata = wbData;
    end else if (!fifoEmpty && headLive) begin
      reg_we    = 1'b1;
      reg_waddr = headAddr;
      reg_wdata = headData;
    end
  end

  // Counts cycles the FIFO waits behind the pipeline; the terminal count raises
  // a one-cycle hold so the following WB bubble drains the head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starveCnt <= '0;
      holdQ     <= 1'b0;
    end else begin
      holdQ <= 1'b0;
      if (fifoPop) begin
        starveCnt <= '0;
      end else if (wbWrites && !fifoEmpty) begin
        if (starveCnt == STV_W'(STARVE_MAX - 1)) begin
          starveCnt <= '0;
          holdQ     <= 1'b1;
        end else begin
          starveCnt <= starveCnt + STV_W'(1);
        end
      end
    end
  end

  wb_retire_fifo #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_retire (
    .clk     (clk),
    .reset   (reset),
    .push    (fifoPush),
    .pushAddr(md_waddr),
    .pushData(md_wdata),
    .pop     (fifoPop),
    .killEn  (wbWrites),
    .killAddr(wbAddr),
    .qAddr0  (q_addr0),
    .qAddr1  (q_addr1),
    .empty   (fifoEmpty),
    .full    (fifoFull),
    .headLive(headLive),
    .headAddr(headAddr),
    .headData(headData),
    .pend0   (pend0),
    .pend1   (pend1)
  );

endmodule
